// File: rtl/harmonic_scheduler.sv
// Per-sample harmonic sequencer: on every sample tick it walks the requested harmonics,
// fetches each phase, drives the sine LUT address and feeds the scaled fraction accumulator.
module harmonic_scheduler #(
    parameter int SAMPLEINTERVAL = 1500,
    parameter int MAX_HARM       = 64,
    parameter int DIV_BIT        = 7
) (
    input  logic               fpga_clock,
    input  logic               reset,
    input  logic [15:0]        frequency,
    input  logic [7:0]         harmonic_count,
    input  logic [DIV_BIT-1:0] decay_step,
    input  logic               pos_ready,
    input  logic [15:0]        sample_pos,
    input  logic               adder_ready,
    output logic [7:0]         harmonic,
    output logic               pos_next,
    output logic [10:0]        lut_addr,
    output logic               adder_start,
    output logic               adder_clear,
    output logic [DIV_BIT-1:0] adder_mult,
    output logic               frame_done,
    output logic               busy,
    output logic               overrun
);

    localparam int                 TICK_W    = (SAMPLEINTERVAL > 1) ? $clog2(SAMPLEINTERVAL) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SAMPLEINTERVAL - 1);
    localparam logic [DIV_BIT-1:0] MULT_FULL = '1;
    localparam logic [7:0]         HARM_MAX  = 8'(MAX_HARM);
    localparam logic [23:0]        NYQUIST   = 24'd32768;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_POS_WAIT,
        S_LUT_WAIT,
        S_ADD_WAIT,
        S_NEXT,
        S_DRAIN,
        S_DRAIN_WAIT,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [TICK_W-1:0]  tick_count_reg;
    logic               tick;
    logic [15:0]        freq_reg, freq_next;
    logic [7:0]         count_reg, count_next;
    logic [DIV_BIT-1:0] decay_reg, decay_next;
    logic [7:0]         harmonic_reg, harmonic_next;
    logic [DIV_BIT-1:0] mult_reg, mult_next;
    logic [10:0]        lut_addr_reg, lut_addr_next;
    logic               overrun_reg;
    logic [7:0]         harmonic_inc;
    logic [7:0]         count_clamped;
    logic [23:0]        product;
    logic               skip;
    logic               in_frame;
    logic               pos_next_c, adder_start_c, adder_clear_c, frame_done_c;

    // Free-running sample timebase; frame activity never stretches it.
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            tick_count_reg <= '0;
        end else if (tick) begin
            tick_count_reg <= '0;
        end else begin
            tick_count_reg <= tick_count_reg + 1'b1;
        end
    end

    assign tick     = (tick_count_reg == TICK_LAST);
    assign in_frame = (state_reg != S_IDLE);

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            overrun_reg <= 1'b0;
        end else if (tick && in_frame) begin
            overrun_reg <= 1'b1;
        end
    end

    assign harmonic_inc  = harmonic_reg + 8'd1;
    assign product       = {8'd0, freq_reg} * {16'd0, harmonic_inc};
    // Harmonics at or above half the phase range alias, and zero-weight ones add nothing.
    assign skip          = (mult_reg == '0) || (product >= NYQUIST);
    assign count_clamped = (harmonic_count == 8'd0)     ? 8'd1 :
                           (harmonic_count > HARM_MAX)  ? HARM_MAX : harmonic_count;

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            freq_reg     <= '0;
            count_reg    <= 8'd1;
            decay_reg    <= '0;
            harmonic_reg <= '0;
            mult_reg     <= MULT_FULL;
            lut_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            freq_reg     <= freq_next;
            count_reg    <= count_next;
            decay_reg    <= decay_next;
            harmonic_reg <= harmonic_next;
            mult_reg     <= mult_next;
            lut_addr_reg <= lut_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        freq_next     = freq_reg;
        count_next    = count_reg;
        decay_next    = decay_reg;
        harmonic_next = harmonic_reg;
        mult_next     = mult_reg;
        lut_addr_next = lut_addr_reg;
        pos_next_c    = 1'b0;
        adder_start_c = 1'b0;
        adder_clear_c = 1'b0;
        frame_done_c  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (tick) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                adder_clear_c = 1'b1;
                harmonic_next = '0;
                mult_next     = MULT_FULL;
                freq_next     = frequency;
                decay_next    = decay_step;
                count_next    = count_clamped;
                state_next    = S_POS_WAIT;
            end
            S_POS_WAIT: begin
                if (pos_ready) begin
                    lut_addr_next = sample_pos[15:5];
                    pos_next_c    = 1'b1;
                    state_next    = S_LUT_WAIT;
                end
            end
            S_LUT_WAIT: begin
                state_next = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (skip) begin
                    state_next = S_NEXT;
                end else if (adder_ready) begin
                    adder_start_c = 1'b1;
                    state_next    = S_NEXT;
                end
            end
            S_NEXT: begin
                harmonic_next = harmonic_inc;
                mult_next     = (mult_reg > decay_reg) ? (mult_reg - decay_reg) : '0;
                state_next    = (harmonic_inc < count_reg) ? S_POS_WAIT : S_DRAIN;
            end
            S_DRAIN: begin
                state_next = S_DRAIN_WAIT;
            end
            S_DRAIN_WAIT: begin
                if (adder_ready) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                frame_done_c = 1'b1;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Flags are masked during reset so the outputs are quiet from the first reset cycle.
    assign pos_next    = pos_next_c & ~reset;
    assign adder_start = adder_start_c & ~reset;
    assign adder_clear = adder_clear_c & ~reset;
    assign frame_done  = frame_done_c & ~reset;
    assign busy        = in_frame & ~reset;
    assign overrun     = overrun_reg & ~reset;
    assign harmonic    = harmonic_reg;
    assign lut_addr    = lut_addr_reg;
    assign adder_mult  = mult_reg;

endmodule
